// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 request/response wires seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and L2.
interface l2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_pmem_read;
  logic              i_pmem_write;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  logic              grant_d;
  logic              busy;

  modport slave (
    input  i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp,
    output grant_d, busy
  );

  modport master (
    output i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp,
    input  grant_d, busy
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 port between I- and D-cache; one transaction in flight.
// Grant registered one cycle after request; granted side held until l2_resp or it drops its request.
module l2_arbiter (
  input  logic          clk,
  input  logic          rst,
  l2_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   req_i, req_d;

  assign req_i = bus.i_pmem_read | bus.i_pmem_write;
  assign req_d = bus.d_pmem_read | bus.d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (req_d && (!req_i || !last_d_q)) begin
          state_d  = D_BUSY;
          last_d_d = 1'b1;
        end else if (req_i) begin
          state_d  = I_BUSY;
          last_d_d = 1'b0;
        end
      end
      I_BUSY: if (bus.l2_resp || !req_i) state_d = IDLE;
      D_BUSY: if (bus.l2_resp || !req_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request steering depends only on state and requester inputs, never on l2_resp.
  always_comb begin
    bus.l2_read     = 1'b0;
    bus.l2_write    = 1'b0;
    bus.l2_address  = '0;
    bus.l2_wdata    = '0;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    case (state_q)
      I_BUSY: begin
        bus.l2_read     = bus.i_pmem_read;
        bus.l2_write    = bus.i_pmem_write;
        bus.l2_address  = bus.i_pmem_address;
        bus.l2_wdata    = bus.i_pmem_wdata;
        bus.i_pmem_resp = bus.l2_resp;
      end
      D_BUSY: begin
        bus.l2_read     = bus.d_pmem_read;
        bus.l2_write    = bus.d_pmem_write;
        bus.l2_address  = bus.d_pmem_address;
        bus.l2_wdata    = bus.d_pmem_wdata;
        bus.d_pmem_resp = bus.l2_resp;
      end
      default: ;
    endcase
  end

  assign bus.i_pmem_rdata = bus.l2_rdata;
  assign bus.d_pmem_rdata = bus.l2_rdata;
  assign bus.grant_d      = (state_q == D_BUSY);
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_l2_arbiter.sv
// Directed vector bench for l2_arbiter: per-cycle table plus a fairness sequence.
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] I_WD  = {4{32'hA5A5_0001}};
  localparam logic [LW-1:0] D_WD  = {4{32'h1234_5678}};
  localparam logic [LW-1:0] L2_RD = {4{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  l2_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          rst, ir, dr, dw, resp;
    logic [AW-1:0] ia, da;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic          e_ir, e_dr, e_gd, e_busy;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic r, logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                              logic [AW-1:0] da, logic resp, logic e_rd, logic e_wr,
                              logic [AW-1:0] e_addr, logic e_ir, logic e_dr,
                              logic e_gd, logic e_busy);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.resp = resp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_gd = e_gd; v.e_busy = e_busy;
    return v;
  endfunction

  // Write data seen on L2 is the granted requester's wdata, zero when idle.
  function automatic logic [149:0] exp_pack(logic rd, logic wr, logic [AW-1:0] a,
                                            logic ir, logic dr, logic gd, logic bsy);
    logic [LW-1:0] wd;
    wd = !bsy ? '0 : (gd ? D_WD : I_WD);
    return {rd, wr, a, wd, ir, dr, gd, bsy};
  endfunction

  function automatic logic [149:0] act_pack();
    return {bus.l2_read, bus.l2_write, bus.l2_address, bus.l2_wdata,
            bus.i_pmem_resp, bus.d_pmem_resp, bus.grant_d, bus.busy};
  endfunction

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  task automatic drive(logic r, logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                       logic [AW-1:0] da, logic resp);
    rst                = r;
    bus.i_pmem_read    = ir;
    bus.i_pmem_write   = 1'b0;
    bus.i_pmem_address = ia;
    bus.i_pmem_wdata   = I_WD;
    bus.d_pmem_read    = dr;
    bus.d_pmem_write   = dw;
    bus.d_pmem_address = da;
    bus.d_pmem_wdata   = D_WD;
    bus.l2_resp        = resp;
    bus.l2_rdata       = L2_RD;
  endtask

  initial begin
    // single I read: grant at +1, resp at +5, idle at +6
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,0, 1,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,0, 1,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,0, 1,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,0, 1,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0,1, 1,0,16'h0040, 1,0,0,1));
    tbl.push_back(mk(0,0,16'h0040,0,0,16'h0,0, 0,0,16'h0000, 0,0,0,0));
    // stray response while idle
    tbl.push_back(mk(0,0,16'h0,0,0,16'h0,1, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,0,16'h0,0,0,16'h0,0, 0,0,16'h0000, 0,0,0,0));
    // tie with last grant = I: D wins, one idle cycle, then I
    tbl.push_back(mk(0,1,16'h0100,0,1,16'h0200,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0100,0,1,16'h0200,0, 0,1,16'h0200, 0,0,1,1));
    tbl.push_back(mk(0,1,16'h0100,0,1,16'h0200,1, 0,1,16'h0200, 0,1,1,1));
    tbl.push_back(mk(0,1,16'h0100,0,0,16'h0200,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0100,0,0,16'h0200,0, 1,0,16'h0100, 0,0,0,1));
    tbl.push_back(mk(0,1,16'h0100,0,0,16'h0200,1, 1,0,16'h0100, 1,0,0,1));
    tbl.push_back(mk(0,0,16'h0100,0,0,16'h0200,0, 0,0,16'h0000, 0,0,0,0));
    // abort: I granted, drops request, pending D granted after the idle cycle
    tbl.push_back(mk(0,1,16'h0040,0,0,16'h0300,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0040,1,0,16'h0300,0, 1,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,0,16'h0040,1,0,16'h0300,0, 0,0,16'h0040, 0,0,0,1));
    tbl.push_back(mk(0,0,16'h0040,1,0,16'h0300,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,0,16'h0040,1,0,16'h0300,0, 1,0,16'h0300, 0,0,1,1));
    tbl.push_back(mk(0,0,16'h0040,1,0,16'h0300,1, 1,0,16'h0300, 0,1,1,1));
    tbl.push_back(mk(0,0,16'h0040,0,0,16'h0300,0, 0,0,16'h0000, 0,0,0,0));
    // reset during D_BUSY, late resp ignored, next tie goes to D again
    tbl.push_back(mk(0,0,16'h0,1,0,16'h0200,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(1,0,16'h0,1,0,16'h0200,0, 1,0,16'h0200, 0,0,1,1));
    tbl.push_back(mk(0,0,16'h0,0,0,16'h0200,1, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0100,1,0,16'h0200,0, 0,0,16'h0000, 0,0,0,0));
    tbl.push_back(mk(0,1,16'h0100,1,0,16'h0200,0, 1,0,16'h0200, 0,0,1,1));
    tbl.push_back(mk(0,1,16'h0100,1,0,16'h0200,1, 1,0,16'h0200, 0,1,1,1));
    tbl.push_back(mk(0,0,16'h0100,0,0,16'h0200,0, 0,0,16'h0000, 0,0,0,0));

    drive(1, 0, '0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].resp);
      #1;
      chk($sformatf("vec%0d", k), 256'(act_pack()),
          256'(exp_pack(tbl[k].e_rd, tbl[k].e_wr, tbl[k].e_addr, tbl[k].e_ir,
                        tbl[k].e_dr, tbl[k].e_gd, tbl[k].e_busy)));
      chk($sformatf("rdata%0d", k), {bus.i_pmem_rdata, bus.d_pmem_rdata}, {L2_RD, L2_RD});
    end

    // fairness: both request continuously, L2 answers on the second busy cycle
    @(negedge clk);
    drive(1, 1, 16'h0100, 0, 1, 16'h0200, 0);
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      logic exp_d;
      exp_d = (t % 2 == 0);
      drive(0, 1, 16'h0100, 0, 1, 16'h0200, 0);
      #1;
      chk($sformatf("fair%0d_idle", t), 256'(act_pack()),
          256'(exp_pack(0, 0, 16'h0, 0, 0, 0, 0)));
      @(negedge clk);
      #1;
      chk($sformatf("fair%0d_grant", t), 256'(act_pack()),
          256'(exp_pack(!exp_d, exp_d, exp_d ? 16'h0200 : 16'h0100, 0, 0, exp_d, 1)));
      @(negedge clk);
      bus.l2_resp = 1'b1;
      #1;
      chk($sformatf("fair%0d_resp", t), 256'(act_pack()),
          256'(exp_pack(!exp_d, exp_d, exp_d ? 16'h0200 : 16'h0100, !exp_d, exp_d, exp_d, 1)));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port round-robin arbiter that shares the single unified-L2 request port between the L1 instruction cache and the L1 data cache. It sits between the two L1 cache `pmem_*` ports and the L2 cache `mem_*` port. It owns the grant state machine, the address and write-data steering, and response routing. One transaction is in flight at a time, and a granted transaction is held until `l2_resp`.

## Interface
- `ADDR_W`, default 16: line address width.
- `LINE_W`, default 128: cache line width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_pmem_read`, `i_pmem_write`  in  1 each  I-cache line read/write request.
- `i_pmem_address`  in  ADDR_W  I-cache line address.
- `i_pmem_wdata`  in  LINE_W  I-cache write line.
- `i_pmem_resp`  out  1  completion strobe to the I-cache.
- `i_pmem_rdata`  out  LINE_W  read line to the I-cache.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_resp`, `d_pmem_rdata`: same as the `i_` ports, for the D-cache.
- `l2_read`, `l2_write`  out  1 each  request to L2.
- `l2_address`  out  ADDR_W  address to L2.
- `l2_wdata`  out  LINE_W  write line to L2.
- `l2_rdata`  in  LINE_W  read line from L2.
- `l2_resp`  in  1  L2 completion strobe.
- `grant_d`  out  1  high while the D-cache owns L2.
- `busy`  out  1  high in any BUSY state.

## Operation
- Per-requester request: `req_i = i_pmem_read | i_pmem_write`; `req_d` likewise.
- State register, 3 states: IDLE, I_BUSY, D_BUSY.
- Register `last_d`: 1 when the most recent grant went to D.
- IDLE transitions:
  - Only `req_i` high: go to I_BUSY.
  - Only `req_d` high: go to D_BUSY.
  - Both high: grant the requester not granted last. D_BUSY if `last_d=0`, else I_BUSY.
  - On entering a BUSY state, `last_d` is set to 1 for D_BUSY, 0 for I_BUSY.
  - Neither high: stay in IDLE.
- BUSY state outputs, all combinational from the granted requester's live inputs:
  - `l2_read`, `l2_write`, `l2_address`, `l2_wdata` pass through unchanged; read+write both high is forwarded as-is.
  - The non-granted requester sees `*_pmem_resp=0` and is never forwarded.
- Response routing:
  - `i_pmem_resp = l2_resp & (state==I_BUSY)`.
  - `d_pmem_resp = l2_resp & (state==D_BUSY)`.
  - `i_pmem_rdata` and `d_pmem_rdata` are both driven by `l2_rdata` at all times; only the resp strobe qualifies them.
- BUSY transitions:
  - `l2_resp=1`: return to IDLE next cycle.
  - Granted requester drops both read and write with `l2_resp=0` (abort): return to IDLE next cycle; no resp issued.
  - Otherwise hold.
- IDLE outputs: `l2_read=l2_write=0`, `l2_address=0`, `l2_wdata=0`, both resp=0. `l2_resp` arriving in IDLE is ignored.
- `grant_d = (state==D_BUSY)`; `busy = (state!=IDLE)`.

## Timing
- Reset (synchronous): state=IDLE, `last_d=0`. After the reset edge: `l2_read=l2_write=0`, `l2_address=0`, `l2_wdata=0`, `i_pmem_resp=d_pmem_resp=0`, `grant_d=0`, `busy=0`.
- Reset asserted mid-transaction: the next edge forces IDLE and drops the L2 request. The outstanding `l2_resp` is then ignored per the IDLE rule.
- Grant latency: request seen in IDLE at cycle N → `l2_read`/`l2_write` high at N+1 (one cycle, registered grant).
- Response is same-cycle: `l2_resp` at cycle M → requester resp at M → IDLE at M+1.
- Mandatory one IDLE cycle between transactions. This lets the requester deate-assert its request after resp so it is not re-granted on a stale request.
- Back-to-back single-requester throughput: one transaction per (L2 latency + 1 cycle).
- Fairness: with both requesting continuously, grants strictly alternate. Maximum wait is one full other-requester transaction.
- First tie after reset goes to D (`last_d=0`).
- No combinational path from `l2_resp` to `l2_read`/`l2_write`.

## Test plan
- Single I read: `i_pmem_read=1`, `i_pmem_address=0x0040` at cycle 0.
  - Required: cycle 1 `l2_read=1`, `l2_address=0x0040`, `busy=1`, `grant_d=0`.
  - L2 returns `l2_rdata=0xDEADBEEF…` with resp at cycle 5 → `i_pmem_resp=1`, `i_pmem_rdata` matches, `d_pmem_resp=0`; IDLE at cycle 6.
- Tie after reset: I read 0x0100 and D write 0x0200 (wdata 0x1234…) requested in the same cycle.
  - Required: D granted first (`l2_write=1`, `l2_address=0x0200`, `l2_wdata` = D data).
  - After D resp: one IDLE cycle, then I granted with `l2_address=0x0100`.
- Fairness: both continuously request for 6 transactions → grant order D, I, D, I, D, I, with exactly one IDLE cycle between each.
- Stray response: `l2_resp=1` pulsed while IDLE → both resps stay 0, state stays IDLE.
- Reset mid-operation: `rst=1` during D_BUSY → next cycle all L2 outputs 0, `busy=0`. An `l2_resp` after the reset produces no resp; the next tie goes to D.
- Abort: granted I-cache drops `i_pmem_read` before `l2_resp` → IDLE next cycle, no `i_pmem_resp`; a pending D request is granted the following cycle.
